// File: rtl/axi_chan_buf_pkg.sv
// Shared AXI channel field types and packed payload widths for axi_chan_buf instances.
// Packed structs fix the packing order: first declared field lands in the MSBs.
package axi_chan_buf_pkg;

    typedef logic [3:0]  axi_id_t;
    typedef logic [31:0] axi_addr_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [63:0] axi_data_t;
    typedef logic [7:0]  axi_strb_t;
    typedef logic [1:0]  axi_resp_t;
    typedef logic        axi_last_t;

    typedef struct packed {
        axi_id_t    id;
        axi_addr_t  addr;
        axi_len_t   len;
        axi_size_t  size;
        axi_burst_t burst;
    } axi_a_chan_t;

    typedef struct packed {
        axi_data_t data;
        axi_strb_t strb;
        axi_last_t last;
    } axi_w_chan_t;

    typedef struct packed {
        axi_id_t   id;
        axi_resp_t resp;
    } axi_b_chan_t;

    typedef struct packed {
        axi_id_t   id;
        axi_data_t data;
        axi_resp_t resp;
        axi_last_t last;
    } axi_r_chan_t;

    localparam int AXI_A_PAYLOAD_W = $bits(axi_a_chan_t);
    localparam int AXI_W_PAYLOAD_W = $bits(axi_w_chan_t);
    localparam int AXI_B_PAYLOAD_W = $bits(axi_b_chan_t);
    localparam int AXI_R_PAYLOAD_W = $bits(axi_r_chan_t);

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/axi_chan_buf_mem.sv
// DEPTH x DATA_W storage for axi_chan_buf: synchronous write, combinational read, no reset.
module axi_chan_buf_mem #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: store the pushed payload at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi_chan_buf.sv
// First-word-fall-through valid/ready channel buffer with registered ready and status.
// Optional statistics (stall_cnt, max_count) are built only with AXI_CHAN_BUF_STATS_EN.
module axi_chan_buf
    import axi_chan_buf_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       afull,
    output logic [31:0]                stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0] max_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          s_ready_r;
    logic          m_valid_r;
    logic          empty_r;
    logic          afull_r;
    logic          push_s;
    logic          pop_s;

    // Handshakes only use registered flags, so m_ready never reaches s_ready.
    assign push_s = s_valid & s_ready_r;
    assign pop_s  = m_valid_r & m_ready;

    // Next occupancy from this cycle's push/pop.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy and status flags, all registered off the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            empty_r   <= 1'b1;
            afull_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r   <= count_s;
            s_ready_r <= (count_s != CW'(DEPTH));
            m_valid_r <= (count_s != CW'(0));
            empty_r   <= (count_s == CW'(0));
            afull_r   <= (count_s >= CW'(AFULL_LVL));
        end
    end

    axi_chan_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (s_data),
        .raddr (rd_ptr_r),
        .rdata (m_data)
    );

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign count   = count_r;
    assign empty   = empty_r;
    assign afull   = afull_r;

`ifdef AXI_CHAN_BUF_STATS_EN
    logic [31:0]   stall_cnt_r;
    logic [CW-1:0] max_count_r;

    // Saturating upstream stall counter and occupancy high-water mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            max_count_r <= '0;
        end else begin
            if (s_valid && !s_ready_r && (stall_cnt_r != STALL_CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (count_s > max_count_r) begin
                max_count_r <= count_s;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign max_count = max_count_r;
`else
    assign stall_cnt = 32'd0;
    assign max_count = CW'(0);
`endif

endmodule

// File: tb/tb_axi_chan_buf.sv
// Self-checking bench for axi_chan_buf (DEPTH=4, AFULL_LVL=3) against a queue-based model.
// Statistics expectations follow AXI_CHAN_BUF_STATS_EN when it is defined for the build.
module tb_axi_chan_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          afull;
    logic [31:0]   stall_cnt;
    logic [CW-1:0] max_count;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_q[$];
    int            stall_ref = 0;
    int            max_ref = 0;

    axi_chan_buf #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .empty(empty), .afull(afull),
        .stall_cnt(stall_cnt), .max_count(max_count)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the FIFO rules to the model.
    task automatic step();
        bit full_b;
        bit push_b;
        bit pop_b;
        full_b = (ref_q.size() == DEPTH);
        push_b = s_valid && !full_b;
        pop_b  = m_ready && (ref_q.size() != 0);
        @(posedge clk);
        if (s_valid && full_b) stall_ref++;
        if (pop_b) void'(ref_q.pop_front());
        if (push_b) ref_q.push_back(s_data);
        if (ref_q.size() > max_ref) max_ref = ref_q.size();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_q.delete();
        stall_ref = 0;
        max_ref = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", afull); end
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        checks++; if (max_count !== CW'(0)) begin errors++; $display("FAIL reset_max got=%0d exp=0", max_count); end
    endtask

    task automatic test_single_push();
        do_reset();
        s_valid = 1'b1; s_data = 16'h00A5;
        step();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_m_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 16'h00A5) begin errors++; $display("FAIL single_m_data got=%h exp=00a5", m_data); end
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", empty); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain_m_valid got=%b exp=0", m_valid); end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp_d;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            step();
            checks++;
            if (afull !== (i >= AFL)) begin errors++; $display("FAIL full_afull count=%0d got=%b exp=%b", i, afull, (i >= AFL)); end
        end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
        s_data = DW'(5);
        step();
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL full_held_count got=%0d exp=4", count); end
        m_ready = 1'b1;
        checks++; if (m_data !== DW'(1)) begin errors++; $display("FAIL full_pop_data got=%0d exp=1", m_data); end
        step();
        m_ready = 1'b0;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got=%b exp=1", s_ready); end
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL full_after_pop_count got=%0d exp=3", count); end
        step();
        s_valid = 1'b0;
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL full_accept5_count got=%0d exp=4", count); end
        m_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            exp_d = DW'(i);
            checks++; if (m_data !== exp_d) begin errors++; $display("FAIL full_drain_order got=%0d exp=%0d", m_data, exp_d); end
            step();
        end
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        s_valid = 1'b1; s_data = 16'h0010; step();
        s_data = 16'h0011; step();
        s_data = 16'h0012; m_ready = 1'b1;
        checks++; if (m_data !== 16'h0010) begin errors++; $display("FAIL simul_pop_data got=%h exp=0010", m_data); end
        step();
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (count !== CW'(2)) begin errors++; $display("FAIL simul_count got=%0d exp=2", count); end
        checks++; if (m_data !== 16'h0011) begin errors++; $display("FAIL simul_next_data got=%h exp=0011", m_data); end
        m_ready = 1'b1; step();
        checks++; if (m_data !== 16'h0012) begin errors++; $display("FAIL simul_order got=%h exp=0012", m_data); end
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            s_valid = (i < 16);
            s_data  = DW'(i);
            if (i > 0) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stream_m_valid i=%0d got=%b exp=1", i, m_valid); end
                checks++; if (m_data !== DW'(i - 1)) begin errors++; $display("FAIL stream_data i=%0d got=%0d exp=%0d", i, m_data, i - 1); end
                checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count); end
            end
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = DW'(16'h0031 + i);
            step();
        end
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready got=%b exp=1", s_ready); end
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b exp=1", empty); end
        #1;
        rst = 1'b0;
        ref_q.delete(); stall_ref = 0; max_ref = 0;
        s_valid = 1'b1; s_data = 16'h0077;
        step();
        s_valid = 1'b0;
        checks++; if (m_data !== 16'h0077) begin errors++; $display("FAIL midrst_fresh_data got=%h exp=0077", m_data); end
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL midrst_fresh_count got=%0d exp=1", count); end
    endtask

    task automatic test_stats();
        int exp_stall;
        int exp_max;
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = DW'(16'h0100 + i);
            step();
        end
        for (int i = 0; i < 5; i++) step();
        s_valid = 1'b0;
`ifdef AXI_CHAN_BUF_STATS_EN
        exp_stall = 5; exp_max = 4;
`else
        exp_stall = 0; exp_max = 0;
`endif
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL stats_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        checks++; if (max_count !== CW'(exp_max)) begin errors++; $display("FAIL stats_max got=%0d exp=%0d", max_count, exp_max); end
    endtask

    task automatic test_random();
        int n;
        int exp_stall;
        int exp_max;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 99) < 60);
            m_ready = ($urandom_range(0, 99) < 45);
            s_data  = DW'($urandom);
            n = ref_q.size();
`ifdef AXI_CHAN_BUF_STATS_EN
            exp_stall = stall_ref; exp_max = max_ref;
`else
            exp_stall = 0; exp_max = 0;
`endif
            checks++; if (count !== CW'(n)) begin errors++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, n); end
            checks++; if (s_ready !== (n != DEPTH)) begin errors++; $display("FAIL rand_s_ready i=%0d got=%b exp=%b", i, s_ready, (n != DEPTH)); end
            checks++; if (m_valid !== (n != 0)) begin errors++; $display("FAIL rand_m_valid i=%0d got=%b exp=%b", i, m_valid, (n != 0)); end
            checks++; if (empty !== (n == 0)) begin errors++; $display("FAIL rand_empty i=%0d got=%b exp=%b", i, empty, (n == 0)); end
            checks++; if (afull !== (n >= AFL)) begin errors++; $display("FAIL rand_afull i=%0d got=%b exp=%b", i, afull, (n >= AFL)); end
            checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL rand_stall i=%0d got=%0d exp=%0d", i, stall_cnt, exp_stall); end
            checks++; if (max_count !== CW'(exp_max)) begin errors++; $display("FAIL rand_max i=%0d got=%0d exp=%0d", i, max_count, exp_max); end
            if (n != 0) begin
                checks++; if (m_data !== ref_q[0]) begin errors++; $display("FAIL rand_m_data i=%0d got=%h exp=%h", i, m_data, ref_q[0]); end
            end
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_chan_buf.md
# axi_chan_buf

Parametrised valid/ready channel buffer for any AXI channel (A, W, B, R) or APB-side staging path. It is a first-word-fall-through FIFO with registered ready and a payload width and depth set per instance. It adds occupancy and almost-full status, and an optional stall and high-water statistics feature. It sits between an AXI channel source and its destination, for example between a master port and the interconnect, with the channel fields packed into one payload vector.

## Interface
Parameters:
- DATA_W, 64: payload width in bits, at least 1; the packed channel fields.
- DEPTH, 4: number of entries; a power of two, at least 2.
- AFULL_LVL, DEPTH-1: almost-full threshold, range 1..DEPTH.

Ports:
- clk  input  1  clock; the block has one clock, and all logic is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  upstream payload valid.
- s_ready  output  1  upstream ready; equals "not full", registered.
- s_data  input  DATA_W  upstream payload.
- m_valid  output  1  downstream valid; equals "not empty".
- m_ready  input  1  downstream ready.
- m_data  output  DATA_W  head-of-queue payload.
- count  output  $clog2(DEPTH+1)  current occupancy.
- empty  output  1  count==0.
- afull  output  1  count>=AFULL_LVL.
- stall_cnt  output  32  stall cycles seen on the upstream side (see Configuration).
- max_count  output  $clog2(DEPTH+1)  occupancy high-water mark (see Configuration).

## Operation
- Push: s_valid&&s_ready at a rising edge. The entry is written at wr_ptr, and wr_ptr increments.
- Pop: m_valid&&m_ready at a rising edge. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update at each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Ordering is strict FIFO. No payload is dropped or duplicated.
- m_data is driven from the array at rd_ptr. Its value is don't-care while m_valid=0.
- s_ready depends only on registered state, never combinationally on m_ready.
  - When full, a pop in the same cycle does not enable a push.
  - s_ready rises in the cycle after the pop.
- Reset values: s_ready=1, m_valid=0, empty=1, afull=0, count=0, stall_cnt=0, max_count=0.
  - Array contents are not reset.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - Stored entries are discarded.
  - Any handshake in the reset cycle is lost.
- Source-side rule: s_data must be held stable while s_valid=1 and s_ready=0. The block does not check this.

## Timing
- Latency: a push at edge N gives m_valid=1 and m_data equal to the pushed payload in the cycle after edge N. There is no combinational bypass from s to m.
- Throughput: one push and one pop per cycle sustained at any DEPTH of 2 or more, provided the buffer is not full.
- count, empty and afull update at the same edge as the push or pop that changes them.
- Full (count==DEPTH): s_ready=0 in that cycle.
- Empty: m_valid=0, and m_ready is ignored.
- When the buffer empties at edge N, m_valid falls in the cycle after edge N.

## Configuration
- Macro: AXI_CHAN_BUF_STATS_EN.
- With the macro defined:
  - stall_cnt increments at each edge where s_valid&&!s_ready, and saturates at 32'hFFFF_FFFF.
  - max_count records the largest count seen since reset.
  - Both clear only on rst.
- Without the macro:
  - stall_cnt and max_count are tied to 0.
  - No statistics registers are built.
  - Port list is unchanged, so instantiations compile either way.

## Structure
- Shared package holds the payload-width constants for each AXI channel, derived from the existing axi_id_t, axi_addr_t, axi_data_t and related typedefs:
  - AXI_A_PAYLOAD_W = id+addr+len+size+burst widths.
  - AXI_W_PAYLOAD_W, AXI_B_PAYLOAD_W, AXI_R_PAYLOAD_W, defined the same way from their channel fields.
- Packing order is fixed in the package: most-significant field first, in the channel's declaration order.
- One sub-module, axi_chan_buf_mem: the DEPTH x DATA_W storage array. It has a synchronous write and a combinational read, and no reset.
- The pointer, count and status logic and the statistics logic live in axi_chan_buf.

## Test plan
- Reset, then push 0xA5 with m_ready=0 -> next cycle m_valid=1, m_data=0xA5, count=1, empty=0.
- DEPTH=4, AFULL_LVL=3, m_ready=0, push 1,2,3,4:
  - afull=1 from count=3.
  - s_ready=0 after the 4th push.
  - A 5th word (5) is held off.
  - Single m_ready pulse -> pops 1, then s_ready=1 the next cycle and 5 is accepted.
- At count=2, assert s_valid and m_ready together for one cycle -> count stays 2, pop returns the oldest word, and order is preserved.
- Stream 0..15 with s_valid and m_ready held at 1 -> one word per cycle, output 0..15 in order, pointers wrap 4 times, count never exceeds 1.
- Push 3 words, then pulse rst between clock edges -> immediately m_valid=0, s_ready=1, count=0, empty=1. After release, the first pop returns the next pushed word, not stale data.
- With AXI_CHAN_BUF_STATS_EN, fill the buffer, then hold s_valid=1 for 5 cycles -> stall_cnt=5, max_count=4. Without the macro, both read 0.
